// File: rtl/outerprodrc_gemm_pkg.sv
// Shared types and helpers for the rate-coded outer-product GEMM tile:
// FSM encoding, stream-mode constants, result-width derivation and bit reversal.
package outerprodrc_gemm_pkg;

  localparam int MODE_EXACT  = 0;
  localparam int MODE_APPROX = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Worst case HIDDEN*(2^N-1)^2 always fits in this many bits.
  function automatic int out_width(input int bitwidth, input int hidden);
    return 2 * bitwidth + $clog2(hidden);
  endfunction

  // Reverses the low 'width' bits of v; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < width; b++) r[b] = v[width-1-b];
    return r;
  endfunction

endpackage

// File: rtl/outerprodrc_gemm_cell.sv
// One output cell: HIDDEN AND gates, a registered popcount stage and the
// running accumulator for that (i,j) position.
module outerprodrc_gemm_cell
  import outerprodrc_gemm_pkg::*;
#(
  parameter int HIDDEN      = 4,
  parameter int OUTBITWIDTH = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [HIDDEN-1:0]      row,
  input  logic [HIDDEN-1:0]      col,
  output logic [OUTBITWIDTH-1:0] acc
);

  localparam int PW = $clog2(HIDDEN + 1);

  logic [PW-1:0] pop;
  logic [PW-1:0] pop_q;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pop = '0;
    for (int k = 0; k < HIDDEN; k++) pop = pop + PW'(row[k] & col[k]);
  end

  // A frozen stream cycle loads zero into the popcount stage, so it adds nothing.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q <= '0;
      acc   <= '0;
    end else if (clr) begin
      pop_q <= '0;
      acc   <= '0;
    end else begin
      pop_q <= en ? pop : '0;
      acc   <= acc + OUTBITWIDTH'(pop_q);
    end
  end

endmodule

// File: rtl/outerprodrc_gemm.sv
// Rate-coded outer-product GEMM tile: latches one operand batch, streams it
// against a shared counter for a fixed window and emits the counted products.
module outerprodrc_gemm
  import outerprodrc_gemm_pkg::*;
#(
  parameter int  HIDDEN      = 4,
  parameter int  ROWNUM      = 2,
  parameter int  COLNUM      = 2,
  parameter int  BITWIDTH    = 8,
  parameter int  MODE        = MODE_EXACT,
  localparam int OUTBITWIDTH = out_width(BITWIDTH, HIDDEN)
) (
  input  logic                                 iClk,
  input  logic                                 iRstN,
  input  logic                                 iEn,
  input  logic                                 iClr,
  input  logic                                 iStart,
  input  logic [HIDDEN*ROWNUM*BITWIDTH-1:0]    iData0,
  input  logic [HIDDEN*COLNUM*BITWIDTH-1:0]    iData1,
  output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] oData,
  output logic                                 oValid,
  output logic                                 oBusy
);

  localparam int CW = (MODE == MODE_APPROX) ? BITWIDTH : 2 * BITWIDTH;

  state_t                                state, state_next;
  logic                                  flushed;
  logic [CW-1:0]                         cnt;
  logic [HIDDEN*ROWNUM*BITWIDTH-1:0]     opa;
  logic [HIDDEN*COLNUM*BITWIDTH-1:0]     opb;
  logic [BITWIDTH-1:0]                   row_slice, col_slice;
  logic [HIDDEN*ROWNUM-1:0]              row_bit;
  logic [HIDDEN*COLNUM-1:0]              col_bit;
  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0]  acc_flat;
  logic                                  start_acc, stream_en, last, done;

  assign start_acc = (state == ST_IDLE) && iStart && !iClr;
  assign stream_en = (state == ST_RUN) && iEn;
  assign last      = stream_en && (cnt == '1);
  assign done      = (state == ST_DRAIN) && flushed && !iClr;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_acc) state_next = ST_RUN;
      ST_RUN:   if (last)      state_next = ST_DRAIN;
      ST_DRAIN: if (flushed)   state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
    if (iClr) state_next = ST_IDLE;
  end

  always_comb begin
    oBusy = (state == ST_RUN) || (state == ST_DRAIN);
  end

  // DRAIN spends one cycle letting the last popcount reach the accumulators.
  // NOTE: operand registers are reset too, keeping the datapath fully defined after reset.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      flushed <= 1'b0;
      cnt     <= '0;
      opa     <= '0;
      opb     <= '0;
      oData   <= '0;
      oValid  <= 1'b0;
    end else begin
      flushed <= (state == ST_DRAIN) && !flushed && !iClr;
      oValid  <= done;
      if (iClr || start_acc) cnt <= '0;
      else if (stream_en)    cnt <= cnt + CW'(1);
      if (start_acc) begin
        opa <= iData0;
        opb <= iData1;
      end
      if (iClr)      oData <= '0;
      else if (done) oData <= acc_flat;
    end
  end

  if (MODE == MODE_APPROX) begin : g_approx
    assign row_slice = cnt[BITWIDTH-1:0];
    assign col_slice = BITWIDTH'(bitrev(32'(cnt), BITWIDTH));
  end else begin : g_exact
    assign row_slice = cnt[BITWIDTH-1:0];
    assign col_slice = cnt[2*BITWIDTH-1:BITWIDTH];
  end

  // A stream bit is 1 while the counter slice is still below the operand.
  for (genvar n = 0; n < HIDDEN * ROWNUM; n++) begin : g_row
    assign row_bit[n] = row_slice < opa[n*BITWIDTH +: BITWIDTH];
  end
  for (genvar n = 0; n < HIDDEN * COLNUM; n++) begin : g_col
    assign col_bit[n] = col_slice < opb[n*BITWIDTH +: BITWIDTH];
  end

  for (genvar i = 0; i < ROWNUM; i++) begin : g_i
    for (genvar j = 0; j < COLNUM; j++) begin : g_j
      logic [HIDDEN-1:0] rv, cv;
      for (genvar k = 0; k < HIDDEN; k++) begin : g_k
        assign rv[k] = row_bit[k*ROWNUM + i];
        assign cv[k] = col_bit[k*COLNUM + j];
      end
      outerprodrc_gemm_cell #(
        .HIDDEN      (HIDDEN),
        .OUTBITWIDTH (OUTBITWIDTH)
      ) u_cell (
        .clk   (iClk),
        .rst_n (iRstN),
        .clr   (iClr || start_acc),
        .en    (stream_en),
        .row   (rv),
        .col   (cv),
        .acc   (acc_flat[(i*COLNUM + j)*OUTBITWIDTH +: OUTBITWIDTH])
      );
    end
  end

endmodule

// File: tb/tb_outerprodrc_gemm.sv
// Directed bench for the rate-coded GEMM tile: exact-mode vector table plus
// hand-written abort, restart, reset and approximate-mode sequences.
module tb_outerprodrc_gemm;

  localparam int OW0 = 9;   // 2*4 + clog2(2)
  localparam int OW1 = 17;  // 2*8 + clog2(2)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [15:0] d0a = '0, d0b = '0;
  logic [31:0] d1a = '0, d1b = '0;
  logic [4*OW0-1:0] q0;
  logic [4*OW1-1:0] q1;
  logic        v0, v1, b0, b1;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  outerprodrc_gemm #(.HIDDEN(2), .ROWNUM(2), .COLNUM(2), .BITWIDTH(4), .MODE(0)) dut0 (
    .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iStart(start0),
    .iData0(d0a), .iData1(d0b), .oData(q0), .oValid(v0), .oBusy(b0)
  );

  outerprodrc_gemm #(.HIDDEN(2), .ROWNUM(2), .COLNUM(2), .BITWIDTH(8), .MODE(1)) dut1 (
    .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iStart(start1),
    .iData0(d1a), .iData1(d1b), .oData(q1), .oValid(v1), .oBusy(b1)
  );

  typedef struct {
    string      name;
    logic [3:0] a[4];
    logic [3:0] b[4];
    int         exp[4];
    bit         stall;
    int         lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pack4(input logic [3:0] e[4]);
    logic [15:0] p;
    for (int n = 0; n < 4; n++) p[n*4 +: 4] = e[n];
    return p;
  endfunction

  // Pulses start0 for one edge; t0 is the cycle count right after that edge.
  task automatic launch0(output int t0);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_valid(input int sel, input int t0, input int budget, output int lat);
    lat = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((sel == 0) ? v0 : v1) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic check_cells0(input string name, input int exp[4]);
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_cell%0d", name, c), q0[c*OW0 +: OW0], exp[c]);
  endtask

  int t0, lat;
  int exp_v0[4];

  initial begin
    vecs[0] = '{"exact",   '{3, 5, 1, 15}, '{2, 7, 15, 1},  '{21, 22, 235, 50}, 1'b0, 258};
    vecs[1] = '{"zeros",   '{0, 0, 0, 0},  '{0, 0, 0, 0},   '{0, 0, 0, 0},      1'b0, 258};
    vecs[2] = '{"max",     '{15,15,15,15}, '{15,15,15,15},  '{450,450,450,450}, 1'b0, 258};
    vecs[3] = '{"mixed",   '{1, 2, 4, 8},  '{3, 0, 2, 9},   '{11, 36, 22, 72},  1'b0, 258};
    vecs[4] = '{"stall",   '{3, 5, 1, 15}, '{2, 7, 15, 1},  '{21, 22, 235, 50}, 1'b1, 268};
    exp_v0 = '{21, 22, 235, 50};

    #2;
    check("reset_odata0", q0, 0);
    check("reset_valid0", v0, 0);
    check("reset_busy0", b0, 0);
    check("reset_odata1", q1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 5; n++) begin
      d0a = pack4(vecs[n].a);
      d0b = pack4(vecs[n].b);
      launch0(t0);
      check({vecs[n].name, "_busy"}, b0, 1);
      if (vecs[n].stall) begin
        repeat (50) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
      end
      wait_valid(0, t0, 400, lat);
      check({vecs[n].name, "_latency"}, lat, vecs[n].lat);
      check_cells0(vecs[n].name, vecs[n].exp);
      check({vecs[n].name, "_busy_done"}, b0, 0);
      @(negedge clk);
      check({vecs[n].name, "_valid_width"}, v0, 0);
      check({vecs[n].name, "_hold"}, q0[3*OW0 +: OW0], vecs[n].exp[3]);
    end

    // Abort mid-RUN: outputs clear, no result ever appears.
    d0a = pack4(vecs[0].a);
    d0b = pack4(vecs[0].b);
    launch0(t0);
    repeat (99) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort_busy", b0, 0);
    check("abort_odata", q0, 0);
    wait_valid(0, t0, 300, lat);
    check("abort_no_valid", lat, -1);

    // Fresh start after abort.
    launch0(t0);
    wait_valid(0, t0, 400, lat);
    check("restart_latency", lat, 258);
    check_cells0("restart", exp_v0);

    // A second iStart during RUN with other operands is ignored.
    launch0(t0);
    repeat (20) @(negedge clk);
    d0a = pack4(vecs[2].a);
    d0b = pack4(vecs[2].b);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_valid(0, t0, 400, lat);
    check("ignored_start_latency", lat, 258);
    check_cells0("ignored_start", exp_v0);

    // iClr beats iStart in the same cycle.
    @(negedge clk);
    clr = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    start0 = 1'b0;
    check("clr_start_busy", b0, 0);
    repeat (5) @(negedge clk);
    check("clr_start_busy_later", b0, 0);
    check("clr_start_odata", q0, 0);

    // Async reset mid-RUN clears outputs without waiting for an edge.
    d0a = pack4(vecs[0].a);
    d0b = pack4(vecs[0].b);
    launch0(t0);
    wait_valid(0, t0, 400, lat);
    check("pre_reset_latency", lat, 258);
    launch0(t0);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_odata", q0, 0);
    check("async_reset_busy", b0, 0);
    check("async_reset_valid", v0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(0, t0, 300, lat);
    check("async_reset_no_valid", lat, -1);

    // Approximate mode: all operands 128 give 64 ones per k over 256 cycles.
    d1a = {4{8'd128}};
    d1b = {4{8'd128}};
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    t0 = cyc;
    wait_valid(1, t0, 400, lat);
    check("approx_latency", lat, 258);
    for (int c = 0; c < 4; c++)
      check($sformatf("approx_cell%0d", c), q1[c*OW1 +: OW1], 128);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
